// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int MEM_AW_DEF = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } lsu_req_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic is_word(
    input logic [1:0] size
  );
    is_word = (size != SZ_BYTE) &&
              (size != SZ_HALF);
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    unique case (1'b1)
      size == SZ_BYTE: misaligned = 1'b0;
      size == SZ_HALF: misaligned = lane[0];
      default:         misaligned = |lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store merge and load extract.
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  function automatic logic [31:0] merge_fn(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  ln
  );
    logic [31:0] m;
    m = old;
    unique case (1'b1)
      sz == SZ_BYTE:
        m[{ln, 3'b000} +: 8] = wd[7:0];
      sz == SZ_HALF:
        m[{ln[1], 4'b0000} +: 16] = wd[15:0];
      default:
        m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract_fn(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] x;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    unique case (1'b1)
      sz == SZ_BYTE:
        x = {{24{sx & b[7]}}, b};
      sz == SZ_HALF:
        x = {{16{sx & h[15]}}, h};
      default:
        x = w;
    endcase
    return x;
  endfunction

  assign merged = merge_fn(word, wdata, size, lane);
  assign rdata  = extract_fn(word, size, lane, sext);

endmodule

// File: rtl/lsu_mem_master.sv
// LSU initiator for the word-addressed data memory.
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       mem_dout
);

  state_t      state;
  lsu_req_t    r;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic        trap;
  logic        unused_addr;

  assign unused_addr = ^addr[31:MEM_AW+2];

  lsu_lane u_lane (
    .word   (mem_dout),
    .wdata  (r.wdata),
    .size   (r.size),
    .lane   (r.lane),
    .sext   (r.sext),
    .merged (merged),
    .rdata  (extracted)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign trap = misaligned(size, addr[1:0]);
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req) begin
      err_q <= trap;
    end
  end
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            r     <= '{we, size, sext,
                       addr[1:0], wdata};
            ready <= 1'b0;
            if (trap) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCESS;
              mem_addr <= addr[MEM_AW+1:2];
              MemRead  <= !(we && is_word(size));
              MemWrite <= we && is_word(size);
              if (we && is_word(size))
                mem_din <= wdata;
            end
          end
        end
        ACCESS: begin
          MemRead <= 1'b0;
          // Sub-word store: read phase done, write merged word next.
          if (r.we && !is_word(r.size)) begin
            state    <= MERGE;
            MemWrite <= 1'b1;
            mem_din  <= merged;
          end else begin
            state    <= DONE;
            MemWrite <= 1'b0;
            done     <= 1'b1;
            if (!r.we)
              rdata <= extracted;
          end
        end
        MERGE: begin
          state    <= DONE;
          MemWrite <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that acts as the initiator for the single-cycle datapath's word-addressed data memory. It takes byte/halfword/word load and store requests from the core and drives the memory's `MemRead`/`MemWrite`/addr/din lines. Sub-word stores are done as read-modify-write, and loaded data is returned sign- or zero-extended. It sits between the EX stage result (address, store data) and the data memory, and stalls the core through `ready`/`done`.

## Interface
- `MEM_AW`, default 5: word-index width driven to memory (32-word memory).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `req` input 1: request strobe; accepted only when `ready`=1.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word; 11 reserved, treated as word.
- `sext` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned.
- `ready` output 1: idle, can accept `req`.
- `done` output 1: one-cycle pulse when the request completes.
- `rdata` output 32: extended load data, valid while `done`=1 and held until the next `done`.
- `err` output 1: misaligned flag, valid with `done`. Present only with the configuration macro; otherwise tied 0.
- `mem_addr` output MEM_AW: equals `addr[MEM_AW+1:2]` of the latched request.
- `mem_din` output 32: write data to memory.
- `MemRead` output 1, `MemWrite` output 1: memory strobes.
- `mem_dout` input 32: combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, MERGE, DONE.
- IDLE: `ready`=1. On `req`, latch `we`, `size`, `sext`, `addr`, `wdata`, then go to ACCESS.
- ACCESS:
  - Load: assert `MemRead`, capture `mem_dout` into the word register, go to DONE.
  - Word store: assert `MemWrite` with `mem_din`=`wdata`, go to DONE.
  - Sub-word store: assert `MemRead`, capture the word, go to MERGE.
- MERGE: assert `MemWrite` with the merged word, go to DONE.
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - Only the selected lane is replaced by the low bits of `wdata`; all other bits are kept from the captured word.
- DONE: `done`=1 and `rdata` updates. Go to IDLE.
- Load extraction: select the lane as above, shift it to bit 0, then sign- or zero-extend per `sext`. A word load ignores `sext`.
- `req` seen while `ready`=0 is ignored: no queueing and no error.
- `MemRead` and `MemWrite` are never both 1. Both are 0 in IDLE and DONE.
- `mem_addr` and `mem_din` are registered outputs; they are held at their last values outside ACCESS/MERGE.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `rdata`=0, `err`=0, `MemRead`=0, `MemWrite`=0, `mem_addr`=0, `mem_din`=0.
- Latency from the accept edge to the `done` pulse:
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
- The memory write commits on the edge that ends ACCESS (word store) or MERGE (sub-word store).
- Back-to-back: `ready` returns in the cycle after `done`, so the minimum issue interval is 3 cycles (word ops) or 4 cycles (sub-word stores).
- Reset asserted mid-operation: the FSM returns to IDLE immediately, strobes drop, and no write is issued after reset.
  - A write already committed before reset remains in memory.
- `addr` beyond the memory range wraps, because only `addr[MEM_AW+1:2]` is used.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, skips ACCESS/MERGE and goes straight to DONE.
  - `err`=1 with `done`; no memory strobe is asserted; `rdata` is unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced to lane alignment (halfword uses `addr[1]` only; word ignores `addr[1:0]`).
  - `err` is constant 0.

## Structure
- `lsu_pkg`: `size` encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and the `MEM_AW` default.
- Sub-module `lsu_lane`: combinational. Holds the store-merge function (old word, `wdata`, `size`, lane → new word) and the load-extract function (word, `size`, lane, `sext` → `rdata`). Used by the FSM top.

## Test plan
- Word store 0xDEADBEEF to addr 0x08, then word load from 0x08 → `MemWrite` with `mem_addr`=2 in cycle 1; load `done` returns `rdata`=0xDEADBEEF two cycles after accept.
- Memory word 0x11223344 at index 1; byte store 0xAA to addr 0x06 → MERGE writes 0x11AA3344; `done` arrives 3 cycles after accept.
- Byte load from addr 0x07 of word 0x80FF0000, `sext`=1 → `rdata`=0xFFFFFF80. With `sext`=0 → 0x00000080.
- Halfword load from addr 0x02 of word 0x80017FFF, `sext`=1 → 0xFFFF8001.
- With the macro defined: word load from addr 0x05 → `done`=1, `err`=1, no strobe, `rdata` unchanged. Without the macro: it reads index 1.
- Pull `rst_n` low during MERGE of a byte store → no `MemWrite`, all outputs at reset values, memory word unchanged; `req` pulsed while busy is ignored.
